payload_char_decoder: RTL

- Front end of the payload-matching engine array: accepts packet payload as a stream of 64-bit words, serialises it to one byte per cycle, and looks each byte up in a programmable 256-entry character-class table.
- Drives the shared per-character match lines `char_class[k]` (the `in_k` inputs of every engine), the byte strobe `en`, and the start-of-data clear `sod`.
- Signals end of packet with `eod` once engine outputs have settled, so the downstream match collector can sample them.

---
 rtl/payload_char_decoder.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/payload_char_decoder.sv
// Payload front end: serialises packet words to one byte per cycle and looks each
// byte up in a programmable 256-entry character-class table for the engine array.
module payload_char_decoder #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_CLASS  = 48,
  parameter int unsigned EOD_DELAY  = 2,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    cfg_we,
  input  logic [7:0]              cfg_addr,
  input  logic [NUM_CLASS-1:0]    cfg_data,
  output logic                    sod,
  output logic                    en,
  output logic [NUM_CLASS-1:0]    char_class,
  output logic                    eod,
  output logic [LEN_WIDTH-1:0]    pkt_len
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOD,
    S_SHIFT,
    S_WAIT_WORD,
    S_EOD_WAIT
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [DATA_WIDTH-1:0] r_data;
  logic [NB-1:0]         r_keep;
  logic                  r_last;
  logic [CNT_W-1:0]      r_eod_cnt;
  logic [NUM_CLASS-1:0]  r_table [256];

  logic                  r_tready;
  logic                  r_sod;
  logic                  r_en;
  logic                  r_eod;
  logic [NUM_CLASS-1:0]  r_char_class;
  logic [LEN_WIDTH-1:0]  r_pkt_len;

  logic                  w_accept;
  logic [NB-1:0]         w_keep_rest;
  logic [7:0]            w_byte;
  logic                  w_issue;
  logic                  w_load;
  logic                  w_clr_len;
  logic                  w_sod_nxt;
  logic                  w_eod_nxt;
  logic                  w_cnt_clr;
  logic                  w_cnt_inc;
  logic                  w_tready_nxt;

  assign w_accept    = r_tready & s_tvalid;
  // Clearing the lowest set keep bit leaves the bytes still to be emitted.
  assign w_keep_rest = r_keep & (r_keep - NB'(1));

  // Select the lowest pending byte; the descending loop lets the lowest index win.
  always_comb begin
    w_byte = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (r_keep[i]) begin
        w_byte = r_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_load      = 1'b0;
    w_clr_len   = 1'b0;
    w_sod_nxt   = 1'b0;
    w_eod_nxt   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_clr_len   = 1'b1;
          w_state_nxt = S_SOD;
        end
      end
      S_SOD: begin
        w_sod_nxt   = 1'b1;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        w_issue = |r_keep;
        if (w_keep_rest == '0) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = r_last ? S_EOD_WAIT : S_WAIT_WORD;
        end
      end
      S_WAIT_WORD: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_EOD_WAIT: begin
        // Counts EOD_DELAY cycles starting the cycle the final en is visible.
        if (r_eod_cnt == CNT_W'(EOD_DELAY - 1)) begin
          w_eod_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_tready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_WAIT_WORD);
  end

  // Held word, pending-byte mask and end-of-data delay counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_keep    <= '0;
      r_last    <= 1'b0;
      r_eod_cnt <= '0;
    end else begin
      if (w_load) begin
        r_data <= s_tdata;
        r_keep <= s_tkeep;
        r_last <= s_tlast;
      end else if (r_state == S_SHIFT) begin
        r_keep <= w_keep_rest;
      end
      if (w_cnt_clr) begin
        r_eod_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_eod_cnt <= r_eod_cnt + CNT_W'(1);
      end
    end
  end

  // Class table is deliberately outside reset; a read in the write cycle sees old data.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      r_table[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tready     <= 1'b0;
      r_sod        <= 1'b0;
      r_en         <= 1'b0;
      r_eod        <= 1'b0;
      r_char_class <= '0;
      r_pkt_len    <= '0;
    end else begin
      r_tready     <= w_tready_nxt;
      r_sod        <= w_sod_nxt;
      r_en         <= w_issue;
      r_eod        <= w_eod_nxt;
      r_char_class <= w_issue ? r_table[w_byte] : '0;
      if (w_clr_len) begin
        r_pkt_len <= '0;
      end else if (w_issue && (r_pkt_len != '1)) begin
        r_pkt_len <= r_pkt_len + LEN_WIDTH'(1);
      end
    end
  end

  assign s_tready   = r_tready;
  assign sod        = r_sod;
  assign en         = r_en;
  assign eod        = r_eod;
  assign char_class = r_char_class;
  assign pkt_len    = r_pkt_len;

endmodule
